// File: rtl/sprite_pkg.sv
// Shared encodings, default geometry and sprite bitmaps for the sprite blit engine.
// Bitmap rows are listed top to bottom; the MSB of each row is column 0 (leftmost pixel).
package sprite_pkg;

    localparam logic [1:0] OP_FLOORS = 2'b00;
    localparam logic [1:0] OP_DRAW   = 2'b01;
    localparam logic [1:0] OP_ERASE  = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLOORS = 2'd1,
        SPRITE = 2'd2
    } state_t;

    localparam int DEF_X_W         = 8;
    localparam int DEF_Y_W         = 7;
    localparam int DEF_COLOR_W     = 3;
    localparam int DEF_SPR_W       = 8;
    localparam int DEF_SPR_H       = 8;
    localparam int DEF_NUM_STYLES  = 4;
    localparam int DEF_SCREEN_W    = 160;
    localparam int DEF_SCREEN_H    = 120;
    localparam int DEF_NUM_FLOORS  = 3;
    localparam int DEF_FLOOR_Y0    = 35;
    localparam int DEF_FLOOR_PITCH = 40;
    localparam int DEF_FLOOR_THICK = 5;
    localparam logic [2:0] DEF_FLOOR_COLOR = 3'b101;

    // Counters are wide enough for any screen raster the engine is built for.
    localparam int CNT_W = 16;

    localparam int BMP_W  = 8;
    localparam int BMP_H  = 8;
    localparam int BMP_XW = $clog2(BMP_W);
    localparam int BMP_YW = $clog2(BMP_H);

    localparam logic [BMP_W-1:0] BMP_NORMAL [BMP_H] = '{
        8'b00111000,
        8'b00111000,
        8'b00010000,
        8'b01111100,
        8'b00010000,
        8'b00101000,
        8'b01000100,
        8'b01000100
    };

    localparam logic [BMP_W-1:0] BMP_CROUCH [BMP_H] = '{
        8'b00000000,
        8'b00000000,
        8'b00111000,
        8'b00111000,
        8'b01111100,
        8'b00010000,
        8'b00101000,
        8'b01101100
    };

endpackage

// File: rtl/sprite_mask_rom.sv
// Combinational sprite mask lookup: (style, row, col) -> opaque bit.
// Spare styles, out-of-range styles and coordinates outside the stored bitmap read as transparent.
module sprite_mask_rom
    import sprite_pkg::*;
#(
    parameter int SPR_W      = DEF_SPR_W,
    parameter int SPR_H      = DEF_SPR_H,
    parameter int NUM_STYLES = DEF_NUM_STYLES,
    parameter int STYLE_W    = $clog2(DEF_NUM_STYLES + 1)
) (
    input  logic [STYLE_W-1:0] style,
    input  logic [CNT_W-1:0]   row,
    input  logic [CNT_W-1:0]   col,
    output logic               mask_o
);

    logic [BMP_W-1:0] line;
    logic             in_range;

    always_comb begin
        line     = '0;
        mask_o   = 1'b0;
        in_range = (int'(style) < NUM_STYLES)
                && (row < CNT_W'(SPR_H)) && (row < CNT_W'(BMP_H))
                && (col < CNT_W'(SPR_W)) && (col < CNT_W'(BMP_W));
        if (in_range) begin
            case (style)
                STYLE_W'(0): line = BMP_NORMAL[row[BMP_YW-1:0]];
                STYLE_W'(1): line = BMP_CROUCH[row[BMP_YW-1:0]];
                default:     line = '0;
            endcase
            mask_o = line[BMP_XW'(BMP_W - 1) - col[BMP_XW-1:0]];
        end
    end

endmodule

// File: rtl/sprite_blit_engine.sv
// Command-driven pixel generator: floor bands or masked sprites, one candidate pixel per clock.
// Optional SPRITE_CLIP_EN suppresses sprite plots falling off the visible screen instead of wrapping.
module sprite_blit_engine
    import sprite_pkg::*;
#(
    parameter int X_W         = DEF_X_W,
    parameter int Y_W         = DEF_Y_W,
    parameter int COLOR_W     = DEF_COLOR_W,
    parameter int SPR_W       = DEF_SPR_W,
    parameter int SPR_H       = DEF_SPR_H,
    parameter int NUM_STYLES  = DEF_NUM_STYLES,
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
    parameter int FLOOR_Y0    = DEF_FLOOR_Y0,
    parameter int FLOOR_PITCH = DEF_FLOOR_PITCH,
    parameter int FLOOR_THICK = DEF_FLOOR_THICK,
    parameter logic [COLOR_W-1:0] FLOOR_COLOR = DEF_FLOOR_COLOR,
    // One extra code point so an out-of-range style can actually be requested.
    parameter int STYLE_W     = $clog2(NUM_STYLES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [X_W-1:0]     cmd_x,
    input  logic [Y_W-1:0]     cmd_y,
    input  logic [STYLE_W-1:0] cmd_style,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic               plot,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [X_W-1:0]     ox_q, ox_d;
    logic [Y_W-1:0]     oy_q, oy_d;
    logic [STYLE_W-1:0] style_q, style_d;
    logic [COLOR_W-1:0] cmd_color_q, cmd_color_d;
    logic [CNT_W-1:0]   cnt_col_q, cnt_col_d;
    logic [CNT_W-1:0]   cnt_row_q, cnt_row_d;
    logic [CNT_W-1:0]   cnt_band_q, cnt_band_d;
    logic               plot_q, plot_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               done_q, done_d;

    logic               accept;
    logic               mask_bit;
    logic               in_screen;
    logic               last;
    logic [CNT_W-1:0]   col_last, row_last, band_last;
    logic [CNT_W-1:0]   floor_row;
    logic [X_W-1:0]     spr_x;
    logic [Y_W-1:0]     spr_y;

    sprite_mask_rom #(
        .SPR_W      (SPR_W),
        .SPR_H      (SPR_H),
        .NUM_STYLES (NUM_STYLES),
        .STYLE_W    (STYLE_W)
    ) u_mask (
        .style  (style_q),
        .row    (cnt_row_q),
        .col    (cnt_col_q),
        .mask_o (mask_bit)
    );

    assign cmd_ready = (state_q == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    // busy covers the done cycle even though the state register is already back in IDLE.
    assign busy      = (state_q != IDLE) || done_q;
    assign plot      = plot_q;
    assign x         = x_q;
    assign y         = y_q;
    assign color     = color_q;
    assign done      = done_q;

    assign floor_row = CNT_W'(FLOOR_Y0) + cnt_band_q * CNT_W'(FLOOR_PITCH) + cnt_row_q;

`ifdef SPRITE_CLIP_EN
    logic [X_W:0] spr_x_full;
    logic [Y_W:0] spr_y_full;
    assign spr_x_full = {1'b0, ox_q} + (X_W+1)'(cnt_col_q);
    assign spr_y_full = {1'b0, oy_q} + (Y_W+1)'(cnt_row_q);
    assign spr_x      = spr_x_full[X_W-1:0];
    assign spr_y      = spr_y_full[Y_W-1:0];
    assign in_screen  = (spr_x_full < (X_W+1)'(SCREEN_W)) && (spr_y_full < (Y_W+1)'(SCREEN_H));
`else
    assign spr_x      = ox_q + X_W'(cnt_col_q);
    assign spr_y      = oy_q + Y_W'(cnt_row_q);
    assign in_screen  = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        style_d     = style_q;
        cmd_color_d = cmd_color_q;
        cnt_col_d   = cnt_col_q;
        cnt_row_d   = cnt_row_q;
        cnt_band_d  = cnt_band_q;
        plot_d      = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        color_d     = color_q;
        done_d      = 1'b0;

        col_last  = (state_q == FLOORS) ? CNT_W'(SCREEN_W - 1)    : CNT_W'(SPR_W - 1);
        row_last  = (state_q == FLOORS) ? CNT_W'(FLOOR_THICK - 1) : CNT_W'(SPR_H - 1);
        band_last = (state_q == FLOORS) ? CNT_W'(NUM_FLOORS - 1)  : '0;
        last      = ((cnt_col_q == col_last) && (cnt_row_q == row_last) && (cnt_band_q == band_last))
                 || ((state_q == SPRITE) && (op_q == OP_NOP));

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d        = cmd_op;
                    ox_d        = cmd_x;
                    oy_d        = cmd_y;
                    style_d     = cmd_style;
                    cmd_color_d = cmd_color;
                    cnt_col_d   = '0;
                    cnt_row_d   = '0;
                    cnt_band_d  = '0;
                    state_d     = (cmd_op == OP_FLOORS) ? FLOORS : SPRITE;
                end
            end
            FLOORS: begin
                plot_d  = 1'b1;
                x_d     = X_W'(cnt_col_q);
                y_d     = floor_row[Y_W-1:0];
                color_d = FLOOR_COLOR;
            end
            SPRITE: begin
                plot_d  = mask_bit && in_screen && (op_q != OP_NOP);
                x_d     = spr_x;
                y_d     = spr_y;
                color_d = (op_q == OP_DRAW) ? cmd_color_q : '0;
            end
            default: state_d = IDLE;
        endcase

        // Raster walk: column fastest, then row, then band.
        if (state_q == FLOORS || state_q == SPRITE) begin
            if (last) begin
                done_d     = 1'b1;
                state_d    = IDLE;
                cnt_col_d  = '0;
                cnt_row_d  = '0;
                cnt_band_d = '0;
            end else if (cnt_col_q != col_last) begin
                cnt_col_d = cnt_col_q + CNT_W'(1);
            end else begin
                cnt_col_d = '0;
                if (cnt_row_q != row_last) begin
                    cnt_row_d = cnt_row_q + CNT_W'(1);
                end else begin
                    cnt_row_d  = '0;
                    cnt_band_d = cnt_band_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            style_q     <= '0;
            cmd_color_q <= '0;
            cnt_col_q   <= '0;
            cnt_row_q   <= '0;
            cnt_band_q  <= '0;
            plot_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            color_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            style_q     <= style_d;
            cmd_color_q <= cmd_color_d;
            cnt_col_q   <= cnt_col_d;
            cnt_row_q   <= cnt_row_d;
            cnt_band_q  <= cnt_band_d;
            plot_q      <= plot_d;
            x_q         <= x_d;
            y_q         <= y_d;
            color_q     <= color_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Directed plus randomized bench for sprite_blit_engine against a raster-list reference model.
// Honours SPRITE_CLIP_EN the same way as the design build.
module tb_sprite_blit_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_x;
    logic [6:0] cmd_y;
    logic [2:0] cmd_style;
    logic [2:0] cmd_color;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_bad = 0;

    // Expected candidate stream and observed plots of the current command.
    bit e_plot[$];
    int e_x[$], e_y[$], e_c[$];
    bit e_xy;
    int p_x[$], p_y[$], p_c[$];
    int n_done;

    logic [7:0] man0 [8] = '{8'b00111000, 8'b00111000, 8'b00010000, 8'b01111100,
                             8'b00010000, 8'b00101000, 8'b01000100, 8'b01000100};
    logic [7:0] man1 [8] = '{8'b00000000, 8'b00000000, 8'b00111000, 8'b00111000,
                             8'b01111100, 8'b00010000, 8'b00101000, 8'b01101100};

    always #5 clk = ~clk;

    sprite_blit_engine dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_style (cmd_style),
        .cmd_color (cmd_color),
        .plot      (plot),
        .x         (x),
        .y         (y),
        .color     (color),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit tb_mask(input int st, input int r, input int c);
        if (st == 0) return man0[r][7-c];
        if (st == 1) return man1[r][7-c];
        return 1'b0;
    endfunction

    function automatic int popcount(input int st);
        int n = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                n += int'(tb_mask(st, r, c));
        return n;
    endfunction

    task automatic build(input int op, input int ox, input int oy, input int st, input int colr);
        e_plot.delete(); e_x.delete(); e_y.delete(); e_c.delete();
        e_xy = 1'b1;
        if (op == 0) begin
            for (int b = 0; b < 3; b++)
                for (int r = 0; r < 5; r++)
                    for (int xx = 0; xx < 160; xx++) begin
                        e_plot.push_back(1'b1); e_x.push_back(xx);
                        e_y.push_back(35 + b*40 + r); e_c.push_back(5);
                    end
        end else if (op == 3) begin
            e_xy = 1'b0;
            e_plot.push_back(1'b0); e_x.push_back(0); e_y.push_back(0); e_c.push_back(0);
        end else begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    int px = ox + c;
                    int py = oy + r;
                    bit m  = tb_mask(st, r, c);
`ifdef SPRITE_CLIP_EN
                    if (px >= 160 || py >= 120) m = 1'b0;
`endif
                    e_plot.push_back(m); e_x.push_back(px % 256);
                    e_y.push_back(py % 128); e_c.push_back(op == 1 ? colr : 0);
                end
        end
    endtask

    // Called #1 after an edge with the engine able to accept; stop_at >= 0 returns after that candidate.
    task automatic run_cmd(input int op, input int ox, input int oy, input int st, input int colr,
                           input bit hold, input int stop_at);
        int n;
        build(op, ox, oy, st, colr);
        n = e_plot.size();
        p_x.delete(); p_y.delete(); p_c.delete();
        n_done = 0;
        cmd_op = 2'(op); cmd_x = 8'(ox); cmd_y = 7'(oy); cmd_style = 3'(st); cmd_color = 3'(colr);
        cmd_valid = 1'b1;
        #1;
        check("ready_before_accept", cmd_ready, 1);
        @(posedge clk); #1;
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd_op = 2'($urandom); cmd_x = 8'($urandom); cmd_y = 7'($urandom);
            cmd_style = 3'($urandom); cmd_color = 3'($urandom);
        end
        check("busy_after_accept", busy, 1);
        check("plot_accept_cycle", plot, 0);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            check("plot", plot, e_plot[k]);
            if (e_xy) begin
                check("x", x, e_x[k]);
                check("y", y, e_y[k]);
                check("color", color, e_c[k]);
            end
            check("done", done, (k == n - 1) ? 1 : 0);
            check("busy", busy, 1);
            if (plot === 1'b1) begin p_x.push_back(x); p_y.push_back(y); p_c.push_back(color); end
            if (done === 1'b1) n_done++;
            if (k == stop_at) return;
        end
        check("ready_with_done", cmd_ready, 1);
        if (!hold) begin
            @(posedge clk); #1;
            check("busy_after_done", busy, 0);
            check("done_single_pulse", done, 0);
            check("plot_after_done", plot, 0);
        end
    endtask

    initial begin
        int cnt;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0;
        cmd_style = '0; cmd_color = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_plot", plot, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_color", color, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", cmd_ready, 1);

        run_cmd(0, 0, 0, 0, 0, 1'b0, -1);
        check("floor_plots", p_x.size(), 2400);
        check("floor_first_x", p_x[0], 0);
        check("floor_first_y", p_y[0], 35);
        check("floor_last_x", p_x[p_x.size()-1], 159);
        check("floor_last_y", p_y[p_y.size()-1], 119);
        cnt = 0;
        foreach (p_y[i]) if (p_y[i] >= 40 && p_y[i] <= 74) cnt++;
        check("floor_gap_rows", cnt, 0);
        check("floor_done_count", n_done, 1);

        run_cmd(1, 25, 25, 0, 7, 1'b0, -1);
        check("draw_popcount", p_x.size(), popcount(0));
        cnt = 0;
        foreach (p_x[i]) if (p_x[i] < 25 || p_x[i] > 32 || p_y[i] < 25 || p_y[i] > 32) cnt++;
        check("draw_in_box", cnt, 0);

        run_cmd(2, 25, 25, 1, 6, 1'b0, -1);
        check("erase_popcount", p_x.size(), popcount(1));
        cnt = 0;
        foreach (p_c[i]) if (p_c[i] != 0) cnt++;
        check("erase_color_zero", cnt, 0);

        run_cmd(1, 156, 118, 0, 2, 1'b0, -1);
`ifdef SPRITE_CLIP_EN
        cnt = 0;
        foreach (p_x[i]) if (p_x[i] >= 160 || p_y[i] >= 120) cnt++;
        check("clip_offscreen", cnt, 0);
`endif

        repeat (6) run_cmd($urandom_range(1, 3), $urandom_range(0, 255), $urandom_range(0, 127),
                           $urandom_range(0, 7), $urandom_range(0, 7), 1'b0, -1);

        run_cmd(1, 40, 50, 0, 4, 1'b0, 30);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_plot", plot, 0);
        check("abort_x", x, 0);
        check("abort_y", y, 0);
        check("abort_color", color, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        @(posedge clk); #1;
        check("abort_plot_held", plot, 0);
        check("abort_done_held", done, 0);
        reset = 1'b0;
        #1;
        check("ready_after_abort", cmd_ready, 1);
        run_cmd(0, 0, 0, 0, 0, 1'b0, -1);
        check("floor2_plots", p_x.size(), 2400);

        run_cmd(1, 10, 10, 5, 3, 1'b1, -1);
        check("bad_style_plots", p_x.size(), 0);
        check("bad_style_done", n_done, 1);
        run_cmd(1, 10, 10, 5, 3, 1'b0, -1);
        check("bad_style2_plots", p_x.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
